// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue: datapath words, function codes, tags and the queue entry.
package issue_queue_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned IQ_TAG_W = 6;
    localparam int unsigned FUN_W    = 4;

    typedef logic [XLEN-1:0]     xlen_t;
    typedef logic [FUN_W-1:0]    fun_t;
    typedef logic [XLEN-1:0]     aux_t;
    typedef logic [IQ_TAG_W-1:0] tag_t;

    typedef struct packed {
        logic            valid;
        logic            opi;
        fun_t            fun;
        tag_t            dst;
        tag_t  [1:0]     src_tag;
        logic  [1:0]     src_rdy;
        xlen_t [1:0]     src_val;
        xlen_t           imm;
        aux_t            aux;
    } iq_entry_t;

    // Tag 0 is the hardwired zero register and never matches a writeback.
    function automatic logic tag_hit(input logic valid, input tag_t src, input tag_t wb);
        return valid && (src != '0) && (src == wb);
    endfunction

endpackage

// File: rtl/iq_select.sv
// Oldest-first issue picker: slot 0 takes any ready op, later slots only non-branch ops.
module iq_select #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2
) (
    input  logic [DEPTH-1:0]                      ready,
    input  logic [DEPTH-1:0]                      opi,
    output logic [WIDTH-1:0]                      sel_valid,
    output logic [WIDTH-1:0][$clog2(DEPTH)-1:0]   sel_idx
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] taken;

    always_comb begin
        taken     = '0;
        sel_valid = '0;
        sel_idx   = '0;
        for (int s = 0; s < WIDTH; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!sel_valid[s] && ready[i] && !taken[i] && ((s == 0) || !opi[i])) begin
                    sel_valid[s] = 1'b1;
                    sel_idx[s]   = IDX_W'(i);
                    taken[i]     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Compacting age-ordered issue queue with writeback wakeup and WIDTH-wide issue.
// Optional IQ_WAKEUP_BYPASS_EN lets a same-cycle writeback make an entry issuable.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned TAG_W = IQ_TAG_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        enq_valid,
    output logic                        enq_ready,
    input  logic                        enq_opi,
    input  fun_t                        enq_fun,
    input  logic [TAG_W-1:0]            enq_dst,
    input  logic [1:0][TAG_W-1:0]       enq_src_tag,
    input  logic [1:0]                  enq_src_rdy,
    input  xlen_t [1:0]                 enq_src_val,
    input  xlen_t                       enq_imm,
    input  aux_t                        enq_aux,
    input  logic [WIDTH-1:0]            wb_valid,
    input  logic [WIDTH-1:0][TAG_W-1:0] wb_tag,
    input  xlen_t [WIDTH-1:0]           wb_val,
    output logic [WIDTH-1:0]            iss_valid,
    input  logic [WIDTH-1:0]            iss_avail,
    output xlen_t [WIDTH-1:0][1:0]      iss_ops,
    output fun_t [WIDTH-1:0]            iss_fun,
    output logic [WIDTH-1:0][TAG_W-1:0] iss_dst,
    output logic [WIDTH-1:0]            iss_opi,
    output xlen_t [WIDTH-1:0]           iss_imm,
    output aux_t [WIDTH-1:0]            iss_aux
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    iq_entry_t                    q     [DEPTH];
    iq_entry_t                    q_nxt [DEPTH];
    logic [CNT_W-1:0]             count;
    logic [CNT_W-1:0]             count_nxt;
    logic [CNT_W-1:0]             wp;
    tag_t [WIDTH-1:0]             wb_tags;
    iq_entry_t                    enq_e;
    logic                         enq_fire;
    logic [DEPTH-1:0]             ready;
    logic [DEPTH-1:0]             opi;
    logic [DEPTH-1:0]             retire;
    logic [WIDTH-1:0]             sel_valid;
    logic [WIDTH-1:0][IDX_W-1:0]  sel_idx;

    // Registered wakeup: lowest writeback port wins because a woken source is not re-matched.
    function automatic iq_entry_t wake(input iq_entry_t e);
        iq_entry_t r;
        r = e;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (!r.src_rdy[k] && tag_hit(wb_valid[j], r.src_tag[k], wb_tags[j])) begin
                    r.src_rdy[k] = 1'b1;
                    r.src_val[k] = wb_val[j];
                end
            end
        end
        return r;
    endfunction

    function automatic logic src_ok(input iq_entry_t e, input int k);
        logic ok;
        ok = e.src_rdy[k];
`ifdef IQ_WAKEUP_BYPASS_EN
        for (int j = 0; j < WIDTH; j++) begin
            ok = ok | tag_hit(wb_valid[j], e.src_tag[k], wb_tags[j]);
        end
`endif
        return ok;
    endfunction

    function automatic xlen_t src_value(input iq_entry_t e, input int k);
        xlen_t v;
        v = e.src_val[k];
`ifdef IQ_WAKEUP_BYPASS_EN
        begin
            logic hit;
            hit = e.src_rdy[k];
            for (int j = 0; j < WIDTH; j++) begin
                if (!hit && tag_hit(wb_valid[j], e.src_tag[k], wb_tags[j])) begin
                    v   = wb_val[j];
                    hit = 1'b1;
                end
            end
        end
`endif
        return v;
    endfunction

    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            wb_tags[j] = IQ_TAG_W'(wb_tag[j]);
        end
    end

    assign enq_ready = (count < CNT_W'(DEPTH));
    assign enq_fire  = enq_valid && enq_ready;

    always_comb begin
        enq_e       = '0;
        enq_e.valid = 1'b1;
        enq_e.opi   = enq_opi;
        enq_e.fun   = enq_fun;
        enq_e.dst   = IQ_TAG_W'(enq_dst);
        enq_e.imm   = enq_imm;
        enq_e.aux   = enq_aux;
        for (int k = 0; k < 2; k++) begin
            enq_e.src_tag[k] = IQ_TAG_W'(enq_src_tag[k]);
            enq_e.src_rdy[k] = enq_src_rdy[k];
            enq_e.src_val[k] = enq_src_rdy[k] ? enq_src_val[k] : '0;
        end
    end

    always_comb begin
        ready = '0;
        opi   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            opi[i]   = q[i].opi;
            ready[i] = q[i].valid && src_ok(q[i], 0) && src_ok(q[i], 1);
        end
    end

    iq_select #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_select (
        .ready     (ready),
        .opi       (opi),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx)
    );

    // Issue payload; an unfilled slot drives all-zero.
    always_comb begin
        iq_entry_t e;
        e         = '0;
        iss_valid = '0;
        iss_ops   = '0;
        iss_fun   = '0;
        iss_dst   = '0;
        iss_opi   = '0;
        iss_imm   = '0;
        iss_aux   = '0;
        retire    = '0;
        for (int s = 0; s < WIDTH; s++) begin
            if (sel_valid[s]) begin
                e             = q[sel_idx[s]];
                iss_valid[s]  = 1'b1;
                iss_ops[s][0] = src_value(e, 0);
                iss_ops[s][1] = src_value(e, 1);
                iss_fun[s]    = e.fun;
                iss_dst[s]    = TAG_W'(e.dst);
                iss_opi[s]    = e.opi;
                iss_imm[s]    = e.imm;
                iss_aux[s]    = e.aux;
                if (iss_avail[s]) begin
                    retire[sel_idx[s]] = 1'b1;
                end
            end
        end
    end

    // Compaction: survivors slide down in age order, the new op lands just above them.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = '0;
        end
        wp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid && !retire[i]) begin
                q_nxt[wp[IDX_W-1:0]] = wake(q[i]);
                wp = wp + CNT_W'(1);
            end
        end
        if (enq_fire) begin
            q_nxt[wp[IDX_W-1:0]] = wake(enq_e);
        end
        count_nxt = wp + CNT_W'(enq_fire);
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_nxt[i] = '0;
            end
            count_nxt = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed scoreboard bench for issue_queue; expected issues are queued per slot and popped by a monitor.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 2;
    localparam int unsigned TAG_W = 6;

    typedef struct packed {
        logic        opi;
        logic [3:0]  fun;
        logic [5:0]  dst;
        logic [31:0] op0;
        logic [31:0] op1;
        logic [31:0] imm;
        logic [31:0] aux;
        logic [31:0] cyc;
    } exp_t;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic                        flush = 1'b0;
    logic                        enq_valid = 1'b0;
    logic                        enq_ready;
    logic                        enq_opi = 1'b0;
    fun_t                        enq_fun = '0;
    logic [TAG_W-1:0]            enq_dst = '0;
    logic [1:0][TAG_W-1:0]       enq_src_tag = '0;
    logic [1:0]                  enq_src_rdy = '0;
    xlen_t [1:0]                 enq_src_val = '0;
    xlen_t                       enq_imm = '0;
    aux_t                        enq_aux = '0;
    logic [WIDTH-1:0]            wb_valid = '0;
    logic [WIDTH-1:0][TAG_W-1:0] wb_tag = '0;
    xlen_t [WIDTH-1:0]           wb_val = '0;
    logic [WIDTH-1:0]            iss_valid;
    logic [WIDTH-1:0]            iss_avail = '1;
    xlen_t [WIDTH-1:0][1:0]      iss_ops;
    fun_t [WIDTH-1:0]            iss_fun;
    logic [WIDTH-1:0][TAG_W-1:0] iss_dst;
    logic [WIDTH-1:0]            iss_opi;
    xlen_t [WIDTH-1:0]           iss_imm;
    aux_t [WIDTH-1:0]            iss_aux;

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t got;
    exp_t want;
    logic have;

    issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_W(TAG_W)) u_dut (
        .clock(clock), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_opi(enq_opi), .enq_fun(enq_fun),
        .enq_dst(enq_dst), .enq_src_tag(enq_src_tag), .enq_src_rdy(enq_src_rdy),
        .enq_src_val(enq_src_val), .enq_imm(enq_imm), .enq_aux(enq_aux),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
        .iss_valid(iss_valid), .iss_avail(iss_avail), .iss_ops(iss_ops), .iss_fun(iss_fun),
        .iss_dst(iss_dst), .iss_opi(iss_opi), .iss_imm(iss_imm), .iss_aux(iss_aux)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every accepted slot must match the oldest expectation queued for that slot.
    always @(negedge clock) begin
        if (reset) begin
            for (int s = 0; s < WIDTH; s++) begin
                if (iss_valid[s] && iss_avail[s]) begin
                    got  = '{opi: iss_opi[s], fun: iss_fun[s], dst: iss_dst[s], op0: iss_ops[s][0],
                             op1: iss_ops[s][1], imm: iss_imm[s], aux: iss_aux[s], cyc: 32'(cyc)};
                    have = 1'b0;
                    want = '0;
                    if (s == 0 && exp_q0.size() > 0) begin want = exp_q0.pop_front(); have = 1'b1; end
                    if (s == 1 && exp_q1.size() > 0) begin want = exp_q1.pop_front(); have = 1'b1; end
                    total++;
                    if (have && got == want) passed++;
                    else $display("FAIL iss_slot%0d: got opi=%b fun=%0d dst=%0d ops=%h/%h imm=%h aux=%h cyc=%0d, want(%0d) opi=%b fun=%0d dst=%0d ops=%h/%h imm=%h aux=%h cyc=%0d",
                                  s, got.opi, got.fun, got.dst, got.op0, got.op1, got.imm, got.aux, got.cyc,
                                  have, want.opi, want.fun, want.dst, want.op0, want.op1, want.imm, want.aux, want.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic set_enq(input logic opi, input logic [3:0] fun, input logic [5:0] dst,
                           input logic [5:0] t0, input logic r0, input logic [31:0] v0,
                           input logic [5:0] t1, input logic r1, input logic [31:0] v1);
        enq_valid      = 1'b1;
        enq_opi        = opi;
        enq_fun        = fun;
        enq_dst        = dst;
        enq_src_tag[0] = t0;
        enq_src_rdy[0] = r0;
        enq_src_val[0] = v0;
        enq_src_tag[1] = t1;
        enq_src_rdy[1] = r1;
        enq_src_val[1] = v1;
        enq_imm        = 32'h1000 + 32'(dst);
        enq_aux        = 32'h8000_0000 | 32'(dst);
    endtask

    task automatic expect_iss(input int slot, input logic opi, input logic [3:0] fun, input logic [5:0] dst,
                              input logic [31:0] v0, input logic [31:0] v1, input int at_cyc);
        exp_t e;
        e = '{opi: opi, fun: fun, dst: dst, op0: v0, op1: v1, imm: 32'h1000 + 32'(dst),
              aux: 32'h8000_0000 | 32'(dst), cyc: 32'(at_cyc)};
        if (slot == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        #11;
        chk("reset_enq_ready", 64'(enq_ready), 64'd1);
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("reset_ops_zero", 64'(|iss_ops), 64'd0);
        chk("reset_payload_zero", 64'(|{iss_fun, iss_dst, iss_opi, iss_imm, iss_aux}), 64'd0);
        step();
        reset = 1'b1;

        // Simple ALU op with both sources ready issues the cycle after enqueue.
        step();
        set_enq(1'b0, 4'd1, 6'd10, 6'd1, 1'b1, 32'd3, 6'd2, 1'b1, 32'd4);
        expect_iss(0, 1'b0, 4'd1, 6'd10, 32'd3, 32'd4, cyc + 1);
        step();
        enq_valid = 1'b0;
        at_neg();
        chk("t1_issue_valid", 64'(iss_valid), 64'd1);
        step();
        at_neg();
        chk("t1_drained", 64'(iss_valid), 64'd0);

        // Wakeup from writeback port 1 two cycles after enqueue.
        step();
        set_enq(1'b0, 4'd2, 6'd11, 6'd5, 1'b0, 32'd0, 6'd3, 1'b1, 32'd7);
        step();
        enq_valid = 1'b0;
        at_neg();
        chk("t2_waiting", 64'(iss_valid), 64'd0);
        step();
        wb_valid  = 2'b11;
        wb_tag[0] = 6'd9;
        wb_val[0] = 32'h99;
        wb_tag[1] = 6'd5;
        wb_val[1] = 32'h55;
`ifdef IQ_WAKEUP_BYPASS_EN
        expect_iss(0, 1'b0, 4'd2, 6'd11, 32'h55, 32'd7, cyc);
        at_neg();
        chk("t2_bypass_issue", 64'(iss_valid), 64'd1);
        step();
        wb_valid = '0;
`else
        expect_iss(0, 1'b0, 4'd2, 6'd11, 32'h55, 32'd7, cyc + 1);
        at_neg();
        chk("t2_not_early", 64'(iss_valid), 64'd0);
        step();
        wb_valid = '0;
        at_neg();
        chk("t2_woken_issue", 64'(iss_valid), 64'd1);
`endif
        step();
        at_neg();
        chk("t2_drained", 64'(iss_valid), 64'd0);

        // Two ports hit the same tag: port 0 value is captured.
        step();
        set_enq(1'b0, 4'd3, 6'd12, 6'd7, 1'b0, 32'd0, 6'd0, 1'b1, 32'd2);
        step();
        enq_valid = 1'b0;
        wb_valid  = 2'b11;
        wb_tag[0] = 6'd7;
        wb_val[0] = 32'h71;
        wb_tag[1] = 6'd7;
        wb_val[1] = 32'h72;
`ifdef IQ_WAKEUP_BYPASS_EN
        expect_iss(0, 1'b0, 4'd3, 6'd12, 32'h71, 32'd2, cyc);
`else
        expect_iss(0, 1'b0, 4'd3, 6'd12, 32'h71, 32'd2, cyc + 1);
`endif
        step();
        wb_valid = '0;
        step();

        // Wakeup applied to the op being enqueued in the same cycle.
        set_enq(1'b0, 4'd4, 6'd13, 6'd8, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1);
        wb_valid  = 2'b10;
        wb_tag[1] = 6'd8;
        wb_val[1] = 32'h88;
        expect_iss(0, 1'b0, 4'd4, 6'd13, 32'h88, 32'd1, cyc + 1);
        step();
        enq_valid = 1'b0;
        wb_valid  = '0;
        step();

        // Oldest ready is a branch: slot 0 branch, slot 1 oldest ALU, third waits.
        iss_avail = '0;
        set_enq(1'b1, 4'd8, 6'd20, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2);
        step();
        set_enq(1'b0, 4'd1, 6'd21, 6'd0, 1'b1, 32'd3, 6'd0, 1'b1, 32'd4);
        step();
        set_enq(1'b0, 4'd1, 6'd22, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd6);
        step();
        enq_valid = 1'b0;
        iss_avail = '1;
        expect_iss(0, 1'b1, 4'd8, 6'd20, 32'd1, 32'd2, cyc);
        expect_iss(1, 1'b0, 4'd1, 6'd21, 32'd3, 32'd4, cyc);
        expect_iss(0, 1'b0, 4'd1, 6'd22, 32'd5, 32'd6, cyc + 1);
        at_neg();
        chk("t3_dual_issue", 64'(iss_valid), 64'd3);
        step();
        at_neg();
        chk("t3_third_next", 64'(iss_valid), 64'd1);

        // A younger branch may not use slot 1.
        step();
        iss_avail = '0;
        set_enq(1'b0, 4'd1, 6'd23, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 32'd8);
        step();
        set_enq(1'b1, 4'd9, 6'd24, 6'd0, 1'b1, 32'd9, 6'd0, 1'b1, 32'd10);
        step();
        enq_valid = 1'b0;
        iss_avail = '1;
        expect_iss(0, 1'b0, 4'd1, 6'd23, 32'd7, 32'd8, cyc);
        expect_iss(0, 1'b1, 4'd9, 6'd24, 32'd9, 32'd10, cyc + 1);
        at_neg();
        chk("t3b_branch_not_slot1", 64'(iss_valid), 64'd1);
        step();
        at_neg();
        chk("t3b_branch_slot0", 64'(iss_valid), 64'd1);

        // Slot 0 not accepted: op stays on slot 0, never migrates to slot 1.
        step();
        set_enq(1'b0, 4'd5, 6'd25, 6'd0, 1'b1, 32'd11, 6'd0, 1'b1, 32'd12);
        step();
        enq_valid = 1'b0;
        iss_avail = 2'b10;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t5_held_slot0", 64'(iss_valid), 64'd1);
            step();
        end
        iss_avail = '1;
        expect_iss(0, 1'b0, 4'd5, 6'd25, 32'd11, 32'd12, cyc);
        at_neg();
        step();

        // Fill with 8 waiting ops, then free one entry.
        for (int i = 0; i < 8; i++) begin
            set_enq(1'b0, 4'd3, 6'(40 + i), 6'(30 + i), 1'b0, 32'd0, 6'd0, 1'b1, 32'(i));
            step();
        end
        enq_valid = 1'b0;
        at_neg();
        chk("t4_full", 64'(enq_ready), 64'd0);
        step();
        set_enq(1'b0, 4'd6, 6'd50, 6'd0, 1'b1, 32'ha, 6'd0, 1'b1, 32'hb);
        wb_valid  = 2'b01;
        wb_tag[0] = 6'd33;
        wb_val[0] = 32'h33;
`ifdef IQ_WAKEUP_BYPASS_EN
        expect_iss(0, 1'b0, 4'd3, 6'd43, 32'h33, 32'd3, cyc);
        at_neg();
        chk("t4_full_while_retiring", 64'(enq_ready), 64'd0);
        step();
        wb_valid = '0;
`else
        step();
        wb_valid = '0;
        expect_iss(0, 1'b0, 4'd3, 6'd43, 32'h33, 32'd3, cyc);
        at_neg();
        chk("t4_full_while_retiring", 64'(enq_ready), 64'd0);
        step();
`endif
        enq_valid = 1'b0;
        at_neg();
        chk("t4_refill_ready", 64'(enq_ready), 64'd1);

        // Flush beats a same-cycle enqueue and wakeup.
        step();
        iss_avail = '0;
        flush     = 1'b1;
        set_enq(1'b0, 4'd1, 6'd51, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
        wb_valid  = 2'b01;
        wb_tag[0] = 6'd30;
        wb_val[0] = 32'h30;
        step();
        flush     = 1'b0;
        enq_valid = 1'b0;
        wb_valid  = '0;
        iss_avail = '1;
        at_neg();
        chk("t6_flush_empty", 64'(iss_valid), 64'd0);
        chk("t6_flush_enq_ready", 64'(enq_ready), 64'd1);
        step();
        wb_valid  = 2'b01;
        wb_tag[0] = 6'd31;
        wb_val[0] = 32'h31;
        at_neg();
        chk("t6_no_survivor", 64'(iss_valid), 64'd0);
        step();
        wb_valid = '0;
        at_neg();
        chk("t6_no_survivor_late", 64'(iss_valid), 64'd0);

        // Asynchronous reset in the middle of a cycle clears outputs at once.
        step();
        iss_avail = '0;
        set_enq(1'b0, 4'd2, 6'd60, 6'd0, 1'b1, 32'h60, 6'd0, 1'b1, 32'h61);
        step();
        enq_valid = 1'b0;
        at_neg();
        chk("t7_held_before_reset", 64'(iss_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t7_reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("t7_reset_ops", 64'(|iss_ops), 64'd0);
        chk("t7_reset_payload", 64'(|{iss_fun, iss_dst, iss_opi, iss_imm, iss_aux}), 64'd0);
        chk("t7_reset_enq_ready", 64'(enq_ready), 64'd1);
        step();
        reset     = 1'b1;
        iss_avail = '1;
        step();
        at_neg();
        chk("t7_empty_after_reset", 64'(iss_valid), 64'd0);

        step();
        chk("slot0_expectations_drained", 64'(exp_q0.size()), 64'd0);
        chk("slot1_expectations_drained", 64'(exp_q1.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Compacting, age-ordered issue queue sitting directly upstream of the functional-unit stage. Accepts one dispatched micro-op per cycle, holds it until both source operands are available, captures operand values from the writeback bus, and presents up to WIDTH ready ops per cycle on the issue interface. Slot 0 is the only slot allowed to carry branch/jump ops (`opi` set), matching the single branch unit behind slot 0.

## Interface
- DEPTH, 8: number of queue entries (≥ WIDTH+1)
- WIDTH, 2: issue slots; also the number of writeback ports
- TAG_W, 6: physical register tag width
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low (0 = reset)
- `flush` in 1: synchronous kill of all entries (branch mispredict)
- `enq_valid` in 1: dispatch offers an op
- `enq_ready` out 1: queue can accept an op this cycle
- `enq_opi` in 1: op is branch/jump class
- `enq_fun` in fun_t: ALU/branch function code
- `enq_dst` in TAG_W: destination tag
- `enq_src_tag` in 2×TAG_W: source tags
- `enq_src_rdy` in 2: source value already valid
- `enq_src_val` in 2×xlen_t: source values (meaningful where rdy)
- `enq_imm` in xlen_t, `enq_aux` in aux_t: immediate, branch PC
- `wb_valid` in WIDTH; `wb_tag` in WIDTH×TAG_W; `wb_val` in WIDTH×xlen_t: writeback/wakeup bus
- `iss_valid` out WIDTH: slot carries a ready op
- `iss_avail` in WIDTH: downstream accepts slot this cycle
- `iss_ops` out WIDTH×2×xlen_t; `iss_fun`, `iss_dst`, `iss_opi`, `iss_imm`, `iss_aux` out per slot: op payload

## Operation
- Entries kept in age order, index 0 oldest; `count` = occupied entries (0..DEPTH).
- Entry ready when valid and both src_rdy set.
- Select: slot 0 takes the oldest ready entry of any class; slot i≥1 takes the oldest ready entry with opi=0 not already picked. Unfilled slots: `iss_valid`=0, payload all-zero.
- Selection ignores `iss_avail`; an op picked for a slot not accepted stays queued and is not moved to another slot that cycle.
- Issue handshake: entry retires at edge when `iss_valid[i] && iss_avail[i]`.
- Compaction: surviving entries shift down preserving order; enqueued op written at position count − retired_this_cycle.
- `enq_ready` = (count < DEPTH), computed from current count only (same-cycle retirements not credited).
- Wakeup: for each valid entry source not ready, any `wb_valid[j]` with matching tag sets rdy and captures `wb_val[j]`. Applied to the enqueuing op too. Multiple matching ports: lowest j wins. Tag 0 never woken (x0 arrives rdy).
- Flush: at edge all entries invalid, count 0; overrides enqueue, wakeup and retirement.
- Reset: all entries invalid, count 0; `enq_ready`=1, `iss_valid`=0, all payload outputs 0.

## Timing
- Enqueue edge N → earliest issue cycle N+1 (entry visible after the edge).
- Wakeup at cycle N → entry issuable at N+1 (without bypass).
- Retire at edge N; vacated entry reusable by enqueue at cycle N+1.
- Full queue: `enq_ready`=0 even if retiring same cycle; refill at N+1.
- Reset mid-operation: outputs forced to reset values immediately, asynchronously.

## Configuration
- `IQ_WAKEUP_BYPASS_EN` defined: select also counts a source as ready if it matches a same-cycle `wb_valid` tag; `iss_ops` muxes `wb_val` in. Wakeup-to-issue latency 0 cycles.
- Undefined: select uses registered rdy only; latency 1 cycle. All other behaviour identical.

## Structure
- Shared package: `xlen_t`, `fun_t`, `aux_t`, tag type, `iq_entry_t` (valid, opi, fun, dst, src_tag[2], src_rdy[2], src_val[2], imm, aux).
- One sub-module: `iq_select` — combinational oldest-first picker producing per-slot index and valid, enforcing slot-0-only for opi.

## Test plan
- Reset release, enqueue ALU op with both src_rdy, vals 3/4, `iss_avail`=1 → cycle after: `iss_valid[0]`=1, `iss_ops[0]`={3,4}; count returns 0.
- Enqueue op waiting on tag 5; `wb_valid[1]`=1, tag 5, val 0x55 two cycles later → issues next cycle (same cycle with bypass) with src value 0x55.
- Oldest ready entry is branch, next two ALU ready → slot 0 branch, slot 1 oldest ALU; third stays queued.
- Fill 8 entries, none ready → `enq_ready`=0; wake one, accept it → `enq_ready` returns 1 the cycle after retire.
- `iss_avail[0]`=0 for 3 cycles with ready op → op held on slot 0, not moved to slot 1, issues when avail rises.
- `flush` with enqueue and wakeup in same cycle → next cycle count 0, `iss_valid`=0; `reset` low mid-flight clears outputs immediately.
